// File: rtl/fifo_rr_wr_arbiter.sv
// fifo_rr_wr_arbiter
// Round-robin write arbiter that lets NUM_REQ producers share one FIFO write
// port. The winning producer owns the port for up to MAX_BURST beats. Ownership
// ends when the burst completes or the owner drops valid. Each write is tagged
// with the owner's index in the top IDW bits of the word.
//
// Ports
//   clk           clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   req_valid     per-producer beat valid
//   req_data      producer i data at [i*WIDTH +: WIDTH]
//   req_ready     per-producer beat accepted this cycle
//   fifo_full     downstream FIFO full flag
//   fifo_wr_en    FIFO write enable
//   fifo_wr_data  {grant_id, owner data}
//   grant_valid   high while a producer owns the port
//   grant_id      current / last owner index
module fifo_rr_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [IDW+WIDTH-1:0]     fifo_wr_data,
  output logic                     grant_valid,
  output logic [IDW-1:0]           grant_id
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   gid_d;
  logic [IDW-1:0]   last_id, last_d;
  logic [CW-1:0]    beat_cnt, cnt_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic             own_valid;
  logic [WIDTH-1:0] owner_data;

  // Search starts just after the previous owner so every producer gets a turn.
  always_comb begin
    logic [IDW-1:0] cand;
    found  = 1'b0;
    winner = last_id;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(last_id) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    own_valid  = req_valid[grant_id];
    owner_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        owner_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_id <= '0;
      last_id  <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= gid_d;
      last_id  <= last_d;
      beat_cnt <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gid_d   = grant_id;
    last_d  = last_id;
    cnt_d   = beat_cnt;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          gid_d   = winner;
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      OWN: begin
        // An idle owner releases even while the FIFO is full.
        if (!own_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!fifo_full) begin
          if (beat_cnt == CW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = beat_cnt + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    grant_valid  = (state_q == OWN);
    fifo_wr_data = {grant_id, owner_data};
    if (rst_n && (state_q == OWN)) begin
      req_ready[grant_id] = !fifo_full;
      fifo_wr_en          = own_valid && !fifo_full;
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
module tb_fifo_rr_wr_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned MB  = 4;
  localparam int unsigned IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [IDW+W-1:0]  fifo_wr_data;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

  always #5 clk = ~clk;

  fifo_rr_wr_arbiter #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  typedef struct {
    logic          rst;
    logic [NR-1:0] v;
    logic          full;
    logic          wr;
    logic [NR-1:0] rdy;
    logic          gv;
    logic [IDW-1:0] gid;
  } vec_t;

  localparam int NT = 19;
  vec_t tbl [NT];

  int checks = 0;
  int errors = 0;

  logic [IDW+W-1:0] exp_q [$];
  int unsigned      wlog [$];
  int unsigned      cyc;
  int unsigned      rem [NR];
  logic [W-1:0]     dat [NR];
  logic             s_wr, s_gv;
  logic [IDW-1:0]   s_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = (rem[i] != 0);
      req_data[i*W +: W] = dat[i];
    end
  endtask

  function automatic bit any_rem();
    bit r = 1'b0;
    for (int i = 0; i < NR; i++) if (rem[i] != 0) r = 1'b1;
    return r;
  endfunction

  // One clock: sample at negedge (scoreboard), then advance producers that handshook.
  task automatic cycle();
    logic [NR-1:0] fire;
    @(negedge clk);
    fire  = req_valid & req_ready;
    s_wr  = fifo_wr_en;
    s_gv  = grant_valid;
    s_gid = grant_id;
    if (fifo_wr_en) begin
      wlog.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_wr_data);
      end else begin
        chk("sb_word", fifo_wr_data, exp_q.pop_front());
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) begin
        rem[i]--;
        dat[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    wlog.delete();
    cyc = 0;
  endtask

  task automatic drain(input int unsigned budget, input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || any_rem()) && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_in_budget"}, 32'(n < budget), 32'd1);
    chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic push(input int id, input int d);
    exp_q.push_back({IDW'(id), W'(d)});
  endtask

  initial begin
    //             rst  v        full wr   rdy      gv   gid
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[5]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[7]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[9]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[11] = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
    tbl[12] = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[13] = '{1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[14] = '{1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
    tbl[15] = '{1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[16] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[17] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[18] = '{1'b1, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    fifo_full = 1'b0;
    cyc       = 0;
    @(posedge clk);
    #1;

    // Per-cycle control vectors: reset, release on idle owner, backpressure,
    // burst limit, mid-burst reset.
    for (int r = 0; r < NT; r++) begin
      rst_n     = tbl[r].rst;
      req_valid = tbl[r].v;
      fifo_full = tbl[r].full;
      @(negedge clk);
      chk($sformatf("row%0d_wr_en", r),       fifo_wr_en,  tbl[r].wr);
      chk($sformatf("row%0d_req_ready", r),   req_ready,   tbl[r].rdy);
      chk($sformatf("row%0d_grant_valid", r), grant_valid, tbl[r].gv);
      chk($sformatf("row%0d_grant_id", r),    grant_id,    tbl[r].gid);
      @(posedge clk);
      #1;
    end

    // Single producer, 6 beats: 4-beat burst, one bubble, re-grant for the rest.
    do_reset();
    rem[2] = 6;
    dat[2] = 8'h10;
    for (int k = 0; k < 6; k++) push(2, 'h10 + k);
    drive();
    drain(40, "single_burst");
    chk("single_burst_nwrites", wlog.size(), 32'd6);
    if (wlog.size() == 6) begin
      int unsigned expc [6] = '{1, 2, 3, 4, 6, 7};
      for (int k = 0; k < 6; k++) chk($sformatf("single_burst_wcyc%0d", k), wlog[k], expc[k]);
    end

    // All producers valid: order 0,1,2,3,0,... with 4 beats and a bubble each.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 8;
      dat[i] = W'(i * 32);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int b = 0; b < MB; b++)
          push(i, i * 32 + r * 4 + b);
    drive();
    drain(100, "fairness");
    chk("fairness_nwrites", wlog.size(), 32'd32);
    if (wlog.size() == 32) begin
      for (int j = 0; j < 32; j++) chk($sformatf("fairness_wcyc%0d", j), wlog[j], 32'(1 + j + j / 4));
    end

    // Owner 3 drops valid after one beat; arbitration wraps to 0.
    do_reset();
    rem[3] = 1;
    dat[3] = 8'hA0;
    push(3, 'hA0);
    drive();
    cycle();
    chk("early_c0_grant_valid", s_gv, 1'b0);
    rem[0] = 2; dat[0] = 8'h01;
    rem[1] = 2; dat[1] = 8'h11;
    push(0, 'h01); push(0, 'h02); push(1, 'h11); push(1, 'h12);
    drive();
    cycle();
    chk("early_c1_wr_en", s_wr, 1'b1);
    chk("early_c1_grant_id", s_gid, 2'd3);
    cycle();
    chk("early_c2_wr_en", s_wr, 1'b0);
    cycle();
    chk("early_c3_bubble", s_gv, 1'b0);
    cycle();
    chk("early_c4_grant_valid", s_gv, 1'b1);
    chk("early_c4_grant_id", s_gid, 2'd0);
    drain(50, "early_release");

    // Reset during owner 1's second beat: no write, req0 wins afterwards, no word lost.
    do_reset();
    rem[1] = 6;
    dat[1] = 8'h30;
    push(1, 'h30);
    drive();
    cycle();
    cycle();
    chk("rst_mid_beat1_wr_en", s_wr, 1'b1);
    chk("rst_mid_beat1_grant_id", s_gid, 2'd1);
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_reset_wr_en", s_wr, 1'b0);
    rst_n  = 1'b1;
    rem[0] = 1;
    dat[0] = 8'h55;
    push(0, 'h55);
    for (int k = 1; k < 6; k++) push(1, 'h30 + k);
    drive();
    cycle();
    chk("rst_mid_after_idle", s_gv, 1'b0);
    cycle();
    chk("rst_mid_regrant_valid", s_gv, 1'b1);
    chk("rst_mid_regrant_id", s_gid, 2'd0);
    drain(60, "rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
